// File: rtl/control_unit_pipe.sv
// Registered ID/EX control decoder: decodes op_code/mode/s_in, gates on the ARM
// condition field, and can expand memory instructions into a multi-beat burst.
module control_unit_pipe #(
  parameter int unsigned CMD_W     = 4,
  parameter int unsigned MEM_BEATS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cond,
  input  logic [3:0]       op_code,
  input  logic [1:0]       mode,
  input  logic             s_in,
  input  logic [3:0]       status,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [CMD_W-1:0] exe_cmd,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic             wb_en,
  output logic             s,
  output logic             b,
  output logic             illegal,
  output logic [2:0]       beat,
  output logic             last_beat
);

  localparam logic [2:0] LastBeat = 3'(MEM_BEATS - 1);
  localparam bit         Bursting = (MEM_BEATS > 1);

  typedef enum logic [0:0] {StRun, StBurst} state_e;

  typedef struct packed {
    logic [3:0] cmd;
    logic       mem_r;
    logic       mem_w;
    logic       wb;
    logic       s;
    logic       b;
    logic       illegal;
  } ctrl_t;

  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d, dec;
  logic       valid_q, valid_d;
  logic [2:0] beat_q, beat_d;
  logic       last_q, last_d;
  logic       cond_pass;
  logic       n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = status;

  always_comb begin
    dec = '0;
    unique case (mode)
      2'b00: begin
        dec.s  = s_in;
        dec.wb = 1'b1;
        unique case (op_code)
          4'b1101: dec.cmd = 4'b0001;
          4'b1111: dec.cmd = 4'b1001;
          4'b0100: dec.cmd = 4'b0010;
          4'b0101: dec.cmd = 4'b0011;
          4'b0010: dec.cmd = 4'b0100;
          4'b0110: dec.cmd = 4'b0101;
          4'b0000: dec.cmd = 4'b0110;
          4'b1100: dec.cmd = 4'b0111;
          4'b0001: dec.cmd = 4'b1000;
          4'b1000: begin
            dec.cmd = 4'b0110;
            dec.wb  = 1'b0;
          end
          4'b1010: begin
            dec.cmd = 4'b0100;
            dec.wb  = 1'b0;
          end
          default: begin
            dec         = '0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      2'b01: begin
        dec.cmd   = 4'b0010;
        dec.mem_r = s_in;
        dec.wb    = s_in;
        dec.mem_w = ~s_in;
      end
      2'b10: begin
        dec.b = 1'b1;
        dec.s = s_in;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  always_comb begin
    cond_pass = 1'b0;
    unique case (cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = ~z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = ~c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = ~n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = ~v_f;
      4'b1000: cond_pass = c_f & ~z_f;
      4'b1001: cond_pass = ~c_f | z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = ~z_f & (n_f == v_f);
      4'b1101: cond_pass = z_f | (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      4'b1111: cond_pass = 1'b0;
    endcase
  end

  assign in_ready = (state_q == StRun) && !stall;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    beat_d  = beat_q;
    last_d  = last_q;
    if (flush) begin
      state_d = StRun;
      valid_d = 1'b0;
      ctrl_d  = '0;
      beat_d  = '0;
      last_d  = 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        StRun: begin
          beat_d = '0;
          if (in_valid) begin
            valid_d = 1'b1;
            last_d  = 1'b1;
            if (!cond_pass) begin
              ctrl_d = '0;
            end else begin
              ctrl_d = dec;
              if ((mode == 2'b01) && Bursting) begin
                state_d = StBurst;
                last_d  = 1'b0;
              end
            end
          end else begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            last_d  = 1'b0;
          end
        end
        StBurst: begin
          beat_d = beat_q + 3'd1;
          if (beat_d == LastBeat) begin
            last_d  = 1'b1;
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      beat_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign exe_cmd   = CMD_W'(ctrl_q.cmd);
  assign mem_r_en  = ctrl_q.mem_r;
  assign mem_w_en  = ctrl_q.mem_w;
  assign wb_en     = ctrl_q.wb;
  assign s         = ctrl_q.s;
  assign b         = ctrl_q.b;
  assign illegal   = ctrl_q.illegal;
  assign beat      = beat_q;
  assign last_beat = last_q;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Bench for control_unit_pipe: directed literal checks plus randomized traffic
// compared every cycle against a queue-based model of the decoder/sequencer.
module tb_control_unit_pipe;

  localparam int MemBeats = 4;

  typedef struct packed {
    logic       v;
    logic [3:0] cmd;
    logic       mr;
    logic       mw;
    logic       wb;
    logic       s;
    logic       b;
    logic       ill;
    logic [2:0] beat;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] cond = 4'hE;
  logic [3:0] op_code = 4'h0;
  logic [1:0] mode = 2'b00;
  logic       s_in = 1'b0;
  logic [3:0] status = 4'h0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;

  logic       in_ready, out_valid, mem_r_en, mem_w_en, wb_en, s, b, illegal, last_beat;
  logic [3:0] exe_cmd;
  logic [2:0] beat;

  int   vectors = 0;
  int   miscompares = 0;
  logic chk_en = 1'b0;
  exp_t model_cur = '0;
  exp_t m_dec, m_beat;
  exp_t mq[$];

  // {legal, exe_cmd} per data-processing opcode, indexed by opcode
  logic [4:0] dp_tab[16] = '{5'h16, 5'h18, 5'h14, 5'h00, 5'h12, 5'h13, 5'h15, 5'h00,
                             5'h16, 5'h00, 5'h14, 5'h00, 5'h17, 5'h11, 5'h00, 5'h19};

  control_unit_pipe #(
    .CMD_W    (4),
    .MEM_BEATS(MemBeats)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cond     (cond),
    .op_code  (op_code),
    .mode     (mode),
    .s_in     (s_in),
    .status   (status),
    .stall    (stall),
    .flush    (flush),
    .out_valid(out_valid),
    .exe_cmd  (exe_cmd),
    .mem_r_en (mem_r_en),
    .mem_w_en (mem_w_en),
    .wb_en    (wb_en),
    .s        (s),
    .b        (b),
    .illegal  (illegal),
    .beat     (beat),
    .last_beat(last_beat)
  );

  always #5 clk = ~clk;

  function automatic exp_t dut_vec();
    return exp_t'({out_valid, exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, illegal, beat,
                   last_beat});
  endfunction

  // Condition codes come in pairs: even code tests a predicate, odd code its inverse.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] st);
    logic nf, zf, cf, vf, base;
    {nf, zf, cf, vf} = st;
    case (c[3:1])
      3'd0:    base = zf;
      3'd1:    base = cf;
      3'd2:    base = nf;
      3'd3:    base = vf;
      3'd4:    base = cf & ~zf;
      3'd5:    base = (nf == vf);
      3'd6:    base = ~zf & (nf == vf);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic exp_t decode(input logic [3:0] op, input logic [1:0] md, input logic si);
    exp_t e;
    logic [4:0] ent;
    e      = '0;
    e.v    = 1'b1;
    e.last = 1'b1;
    case (md)
      2'b00: begin
        ent = dp_tab[op];
        if (ent[4]) begin
          e.cmd = ent[3:0];
          e.s   = si;
          e.wb  = (op != 4'b1000) && (op != 4'b1010);
        end else begin
          e.ill = 1'b1;
        end
      end
      2'b01: begin
        e.cmd = 4'b0010;
        e.mr  = si;
        e.wb  = si;
        e.mw  = ~si;
      end
      2'b10: begin
        e.b = 1'b1;
        e.s = si;
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Reference model: a burst is a queue of pre-built beats drained one per unstalled cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_cur = '0;
      mq.delete();
    end else if (flush) begin
      model_cur = '0;
      mq.delete();
    end else if (!stall) begin
      if (mq.size() != 0) begin
        model_cur = mq.pop_front();
      end else if (in_valid) begin
        m_dec = decode(op_code, mode, s_in);
        if (!cond_ok(cond, status)) begin
          model_cur      = '0;
          model_cur.v    = 1'b1;
          model_cur.last = 1'b1;
        end else if (mode == 2'b01) begin
          for (int i = 0; i < MemBeats; i++) begin
            m_beat      = m_dec;
            m_beat.beat = 3'(i);
            m_beat.last = (i == MemBeats - 1);
            mq.push_back(m_beat);
          end
          model_cur = mq.pop_front();
        end else begin
          model_cur = m_dec;
        end
      end else begin
        model_cur = '0;
      end
    end
  end

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("model_out", dut_vec(), model_cur);
      check("model_ready", {14'b0, in_ready}, {14'b0, (mq.size() == 0) && !stall});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic present(input logic v, input logic [3:0] cd, input logic [1:0] md,
                         input logic [3:0] op, input logic si);
    in_valid = v;
    cond     = cd;
    mode     = md;
    op_code  = op;
    s_in     = si;
  endtask

  localparam exp_t Bubble = '0;

  initial begin
    // reset / idle
    tick();
    tick();
    check("reset_out", dut_vec(), Bubble);
    check("reset_ready", {14'b0, in_ready}, 15'd1);
    rst    = 1'b1;
    chk_en = 1'b1;
    tick();
    check("idle_out", dut_vec(), Bubble);

    // full decode sweep under AL
    for (int op = 0; op < 16; op++) begin
      status = 4'($urandom);
      present(1'b1, 4'hE, 2'b00, 4'(op), 1'b1);
      tick();
      if (op == 4)  check("add", dut_vec(), {1'b1, 4'b0010, 6'b001100, 3'd0, 1'b1});
      if (op == 10) check("cmp", dut_vec(), {1'b1, 4'b0100, 6'b000100, 3'd0, 1'b1});
      if (op == 3)  check("op0011", dut_vec(), {1'b1, 4'b0000, 6'b000001, 3'd0, 1'b1});
    end

    // condition gating
    status = 4'b0100;
    present(1'b1, 4'h0, 2'b00, 4'b0100, 1'b1);
    tick();
    check("eq_pass", dut_vec(), {1'b1, 4'b0010, 6'b001100, 3'd0, 1'b1});
    status = 4'b0000;
    tick();
    check("eq_fail", dut_vec(), {1'b1, 4'b0000, 6'b000000, 3'd0, 1'b1});
    status = 4'b0100;
    present(1'b1, 4'hF, 2'b00, 4'b0100, 1'b1);
    tick();
    check("nv_never", dut_vec(), {1'b1, 4'b0000, 6'b000000, 3'd0, 1'b1});

    // store: first beat
    present(1'b1, 4'hE, 2'b01, 4'h0, 1'b0);
    tick();
    check("str_b0", dut_vec(), {1'b1, 4'b0010, 6'b010000, 3'd0, 1'b0});
    present(1'b0, 4'hE, 2'b00, 4'h0, 1'b0);
    repeat (4) tick();

    // load burst with a waiting ADD behind it
    present(1'b1, 4'hE, 2'b01, 4'h0, 1'b1);
    tick();
    check("ldr_b0", dut_vec(), {1'b1, 4'b0010, 6'b101000, 3'd0, 1'b0});
    check("ldr_rdy0", {14'b0, in_ready}, 15'd0);
    present(1'b1, 4'hE, 2'b00, 4'b0100, 1'b1);
    tick();
    check("ldr_b1", dut_vec(), {1'b1, 4'b0010, 6'b101000, 3'd1, 1'b0});
    check("ldr_rdy1", {14'b0, in_ready}, 15'd0);
    tick();
    check("ldr_b2", dut_vec(), {1'b1, 4'b0010, 6'b101000, 3'd2, 1'b0});
    check("ldr_rdy2", {14'b0, in_ready}, 15'd0);
    tick();
    check("ldr_b3", dut_vec(), {1'b1, 4'b0010, 6'b101000, 3'd3, 1'b1});
    check("ldr_rdy3", {14'b0, in_ready}, 15'd1);
    tick();
    check("after_burst", dut_vec(), {1'b1, 4'b0010, 6'b001100, 3'd0, 1'b1});

    // stall mid-burst at beat 1
    present(1'b1, 4'hE, 2'b01, 4'h0, 1'b1);
    tick();
    present(1'b1, 4'hE, 2'b00, 4'b0100, 1'b1);
    tick();
    stall = 1'b1;
    tick();
    check("stall_hold1", dut_vec(), {1'b1, 4'b0010, 6'b101000, 3'd1, 1'b0});
    tick();
    check("stall_hold2", dut_vec(), {1'b1, 4'b0010, 6'b101000, 3'd1, 1'b0});
    stall = 1'b0;
    tick();
    check("stall_b2", dut_vec(), {1'b1, 4'b0010, 6'b101000, 3'd2, 1'b0});
    in_valid = 1'b0;
    tick();
    check("stall_b3", dut_vec(), {1'b1, 4'b0010, 6'b101000, 3'd3, 1'b1});
    tick();
    check("stall_bubble", dut_vec(), Bubble);

    // flush together with stall at beat 2
    present(1'b1, 4'hE, 2'b01, 4'h0, 1'b1);
    tick();
    present(1'b1, 4'hE, 2'b00, 4'b0100, 1'b1);
    tick();
    tick();
    flush = 1'b1;
    stall = 1'b1;
    tick();
    check("flush_out", dut_vec(), Bubble);
    flush    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_ready", {14'b0, in_ready}, 15'd1);
    tick();
    check("flush_discard", dut_vec(), Bubble);

    // reset asserted mid-burst
    present(1'b1, 4'hE, 2'b01, 4'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rst_midburst", dut_vec(), Bubble);
    check("rst_ready", {14'b0, in_ready}, 15'd1);
    tick();
    rst = 1'b1;
    tick();
    check("rst_after", dut_vec(), Bubble);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rst      = ($urandom_range(0, 299) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      cond     = ($urandom_range(0, 1) != 0) ? 4'hE : 4'($urandom);
      op_code  = 4'($urandom);
      mode     = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'($urandom);
      s_in     = 1'($urandom);
      status   = 4'($urandom);
      stall    = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      tick();
    end

    rst      = 1'b1;
    in_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    repeat (6) tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
